// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Register 0 is hard-wired, so writes aimed at it are dropped and counted.
package regfile_write_arbiter_pkg;

  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int ZERO_REG  = 0;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin grant logic for the write-back arbiter.
// The grant is combinational and the rotating pointer is registered.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] reqValid,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rrPtr;
  logic [PTR_W-1:0] rrPtrNext;
  logic             found;

  // First pass covers requesters at or after the pointer, second pass wraps to 0.
  always_comb begin
    grant     = '0;
    rrPtrNext = rrPtr;
    found     = 1'b0;
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && reqValid[i] && (i >= int'(rrPtr))) begin
          grant[i]  = 1'b1;
          found     = 1'b1;
          rrPtrNext = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && reqValid[i]) begin
          grant[i]  = 1'b1;
          found     = 1'b1;
          rrPtrNext = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr <= '0;
    end else begin
      rrPtr <= rrPtrNext;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-back arbiter feeding one register-file write port.
// Define WB_FORWARD_EN to enable bypass of the registered write to two read ports.
module regfile_write_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int REG_IDX_W = regfile_write_arbiter_pkg::REG_IDX_W
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [NUM_REQ-1:0]                              reqValid,
  input  logic [NUM_REQ*REG_IDX_W-1:0]                    reqIndex,
  input  logic [NUM_REQ*regfile_write_arbiter_pkg::DATA_W-1:0] reqValue,
  output logic [NUM_REQ-1:0]                              reqReady,
  output logic                                            wrEn,
  output logic [REG_IDX_W-1:0]                            wrIndex,
  output logic [regfile_write_arbiter_pkg::DATA_W-1:0]    wrValue,
  output logic [7:0]                                      zeroDrops,
  input  logic [REG_IDX_W-1:0]                            fwdIndexA,
  input  logic [REG_IDX_W-1:0]                            fwdIndexB,
  output logic                                            fwdHitA,
  output logic                                            fwdHitB,
  output logic [regfile_write_arbiter_pkg::DATA_W-1:0]    fwdValueA,
  output logic [regfile_write_arbiter_pkg::DATA_W-1:0]    fwdValueB
);

  import regfile_write_arbiter_pkg::*;

  logic                 grantAny;
  logic [REG_IDX_W-1:0] selIndex;
  logic [DATA_W-1:0]    selValue;
  logic                 selIsZero;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) uArb (
    .clk      (clk),
    .reset    (reset),
    .reqValid (reqValid),
    .grant    (reqReady)
  );

  // One-hot grant lets the data mux be a plain AND-OR.
  always_comb begin
    selIndex = '0;
    selValue = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reqReady[i]) begin
        selIndex = selIndex | reqIndex[i*REG_IDX_W +: REG_IDX_W];
        selValue = selValue | reqValue[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grantAny  = |reqReady;
  assign selIsZero = (selIndex == REG_IDX_W'(ZERO_REG));

  // Index and value stay 0 whenever no write is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrEn    <= 1'b0;
      wrIndex <= '0;
      wrValue <= '0;
    end else if (grantAny && !selIsZero) begin
      wrEn    <= 1'b1;
      wrIndex <= selIndex;
      wrValue <= selValue;
    end else begin
      wrEn    <= 1'b0;
      wrIndex <= '0;
      wrValue <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zeroDrops <= '0;
    end else if (grantAny && selIsZero && (zeroDrops != DROP_CNT_MAX)) begin
      zeroDrops <= zeroDrops + 8'd1;
    end
  end

`ifdef WB_FORWARD_EN
  assign fwdHitA   = wrEn && (wrIndex == fwdIndexA);
  assign fwdHitB   = wrEn && (wrIndex == fwdIndexB);
  assign fwdValueA = fwdHitA ? wrValue : '0;
  assign fwdValueB = fwdHitB ? wrValue : '0;
`else
  logic unusedFwdIndex;
  assign unusedFwdIndex = ^{fwdIndexA, fwdIndexB};
  assign fwdHitA   = 1'b0;
  assign fwdHitB   = 1'b0;
  assign fwdValueA = '0;
  assign fwdValueB = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (NUM_REQ=3).
// Inputs change on the falling edge; registered outputs are checked there too.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  reqValid;
  logic [14:0] reqIndex;
  logic [95:0] reqValue;
  logic [2:0]  reqReady;
  logic        wrEn;
  logic [4:0]  wrIndex;
  logic [31:0] wrValue;
  logic [7:0]  zeroDrops;
  logic [4:0]  fwdIndexA;
  logic [4:0]  fwdIndexB;
  logic        fwdHitA;
  logic        fwdHitB;
  logic [31:0] fwdValueA;
  logic [31:0] fwdValueB;

  int checkCount;
  int failCount;
  int sawWrEn;

  regfile_write_arbiter #(
    .NUM_REQ   (3),
    .REG_IDX_W (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reqValid  (reqValid),
    .reqIndex  (reqIndex),
    .reqValue  (reqValue),
    .reqReady  (reqReady),
    .wrEn      (wrEn),
    .wrIndex   (wrIndex),
    .wrValue   (wrValue),
    .zeroDrops (zeroDrops),
    .fwdIndexA (fwdIndexA),
    .fwdIndexB (fwdIndexB),
    .fwdHitA   (fwdHitA),
    .fwdHitB   (fwdHitB),
    .fwdValueA (fwdValueA),
    .fwdValueB (fwdValueB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Drives all three requesters at once; call right after a falling edge.
  task automatic applyStimulus(input logic [2:0] valid,
                               input logic [4:0] i0, input logic [4:0] i1, input logic [4:0] i2,
                               input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    reqValid = valid;
    reqIndex = {i2, i1, i0};
    reqValue = {v2, v1, v0};
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    sawWrEn    = 0;
    reset      = 1'b1;
    fwdIndexA  = 5'd0;
    fwdIndexB  = 5'd0;
    applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'h101, 32'h102, 32'h103);

    @(negedge clk);
    #1 checkOutput("readyDuringReset", 32'(reqReady), 32'h0);
    tick();
    checkOutput("rstWrEn", 32'(wrEn), 32'h0);
    checkOutput("rstWrIndex", 32'(wrIndex), 32'h0);
    checkOutput("rstWrValue", wrValue, 32'h0);
    checkOutput("rstZeroDrops", 32'(zeroDrops), 32'h0);
    checkOutput("rstFwdHitA", 32'(fwdHitA), 32'h0);

    // Three requesters held valid: grants rotate 0,1,2,0
    reset = 1'b0;
    #1 checkOutput("rrReady0", 32'(reqReady), 32'h1);
    tick();
    checkOutput("rrWrIndex0", 32'(wrIndex), 32'd1);
    checkOutput("rrWrValue0", wrValue, 32'h101);
    checkOutput("rrReady1", 32'(reqReady), 32'h2);
    tick();
    checkOutput("rrWrIndex1", 32'(wrIndex), 32'd2);
    checkOutput("rrReady2", 32'(reqReady), 32'h4);
    tick();
    checkOutput("rrWrIndex2", 32'(wrIndex), 32'd3);
    checkOutput("rrWrValue2", wrValue, 32'h103);
    checkOutput("rrReadyWrap", 32'(reqReady), 32'h1);
    tick();
    checkOutput("rrWrIndexWrap", 32'(wrIndex), 32'd1);
    checkOutput("rrWrEnWrap", 32'(wrEn), 32'h1);
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1 checkOutput("idleReady", 32'(reqReady), 32'h0);
    tick();
    checkOutput("idleWrEn", 32'(wrEn), 32'h0);
    checkOutput("idleWrIndex", 32'(wrIndex), 32'h0);

    // Single request on requester 1
    applyStimulus(3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0);
    #1 checkOutput("singleReady", 32'(reqReady), 32'h2);
    tick();
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("singleWrEn", 32'(wrEn), 32'h1);
    checkOutput("singleWrIndex", 32'(wrIndex), 32'd7);
    checkOutput("singleWrValue", wrValue, 32'hDEADBEEF);
    tick();
    checkOutput("singleWrEnAfter", 32'(wrEn), 32'h0);
    checkOutput("singleWrIndexAfter", 32'(wrIndex), 32'h0);
    checkOutput("singleWrValueAfter", wrValue, 32'h0);

    // 300 writes to register 0: dropped, counter saturates
    applyStimulus(3'b111, 5'd0, 5'd0, 5'd0, 32'hAAAA, 32'hBBBB, 32'hCCCC);
    for (int n = 0; n < 300; n++) begin
      tick();
      if (wrEn !== 1'b0) sawWrEn++;
      if (n == 99) checkOutput("zeroDrops100", 32'(zeroDrops), 32'd100);
    end
    checkOutput("zeroWrEnNever", 32'(sawWrEn), 32'd0);
    checkOutput("zeroDropsSat", 32'(zeroDrops), 32'd255);
    checkOutput("zeroWrIndex", 32'(wrIndex), 32'h0);
    for (int n = 0; n < 5; n++) tick();
    checkOutput("zeroDropsHold", 32'(zeroDrops), 32'd255);

    // Reset right after a grant of index 5 discards the pending write
    applyStimulus(3'b001, 5'd5, 5'd0, 5'd0, 32'h55, 32'h0, 32'h0);
    #1 checkOutput("preRstReady", 32'(reqReady), 32'h1);
    tick();
    checkOutput("preRstWrEn", 32'(wrEn), 32'h1);
    checkOutput("preRstWrIndex", 32'(wrIndex), 32'd5);
    reset = 1'b1;
    applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    #1 checkOutput("midRstReady", 32'(reqReady), 32'h0);
    tick();
    checkOutput("postRstWrEn", 32'(wrEn), 32'h0);
    checkOutput("postRstWrIndex", 32'(wrIndex), 32'h0);
    checkOutput("postRstZeroDrops", 32'(zeroDrops), 32'h0);
    reset = 1'b0;
    #1 checkOutput("postRstReady", 32'(reqReady), 32'h1);
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();

    // Forwarding of the registered write to the two read ports
    fwdIndexA = 5'd9;
    fwdIndexB = 5'd4;
    checkOutput("fwdIdleHitA", 32'(fwdHitA), 32'h0);
    applyStimulus(3'b001, 5'd9, 5'd0, 5'd0, 32'h12345678, 32'h0, 32'h0);
    tick();
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("fwdWrIndex", 32'(wrIndex), 32'd9);
`ifdef WB_FORWARD_EN
    checkOutput("fwdHitA", 32'(fwdHitA), 32'h1);
    checkOutput("fwdValueA", fwdValueA, 32'h12345678);
`else
    checkOutput("fwdHitA", 32'(fwdHitA), 32'h0);
    checkOutput("fwdValueA", fwdValueA, 32'h0);
`endif
    checkOutput("fwdHitB", 32'(fwdHitB), 32'h0);
    checkOutput("fwdValueB", fwdValueB, 32'h0);
    tick();
    checkOutput("fwdAfterHitA", 32'(fwdHitA), 32'h0);
    checkOutput("fwdAfterValueA", fwdValueA, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
